// File: rtl/deco_pkg.sv
// Shared types and helpers for the registered one-hot scan decoder.
package deco_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_e;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  // Level an output channel takes when it is not selected.
  function automatic logic inactive_level(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/onehot_scan_deco_if.sv
// Control and status bundle of the one-hot scan decoder.
// master drives the controls; slave is the decoder side.
interface onehot_scan_deco_if #(
  parameter int N = 8
);
  import deco_pkg::*;

  localparam int IW = $clog2(N);

  logic          en;
  mode_e         mode;
  logic [IW-1:0] sel;
  logic [N-1:0]  mask;
  logic [N-1:0]  out;
  logic [IW-1:0] idx;
  logic          tick;
  logic          wrap;

  modport master (
    output en, mode, sel, mask,
    input  out, idx, tick, wrap
  );

  modport slave (
    input  en, mode, sel, mask,
    output out, idx, tick, wrap
  );

endinterface

// File: rtl/next_chan_find.sv
// Combinational search for the next enabled scan channel.
// Picks the lowest set mask bit above cur (or at cur when inclusive);
// when none exists it falls back to the lowest set bit and flags a wrap.
module next_chan_find #(
  parameter int N = 8
) (
  input  logic [N-1:0]          mask,
  input  logic [$clog2(N)-1:0]  cur,
  input  logic                  inclusive,
  output logic [$clog2(N)-1:0]  nxt,
  output logic                  found,
  output logic                  wrapped
);

  localparam int IW = $clog2(N);

  logic          hit_above;
  logic [IW-1:0] above_idx;
  logic [IW-1:0] low_idx;

  // Walk downwards so the last match written is the lowest qualifying bit.
  always_comb begin
    hit_above = 1'b0;
    above_idx = '0;
    low_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) begin
        low_idx = IW'(i);
        if ((i > int'(cur)) || (inclusive && (i == int'(cur)))) begin
          hit_above = 1'b1;
          above_idx = IW'(i);
        end
      end
    end
    found   = |mask;
    wrapped = found && !hit_above;
    nxt     = hit_above ? above_idx : low_idx;
  end

endmodule

// File: rtl/onehot_scan_deco.sv
// Registered 1-of-N decoder with DIRECT decode and a prescaled SCAN mode
// that rotates a one-hot select across the channels enabled in mask.
// Optional macro DECO_BLANK_EN: inserts one all-inactive cycle before
// every scan advance (DIV must then be at least 2).
module onehot_scan_deco
  import deco_pkg::*;
#(
  parameter int N          = 8,
  parameter int DIV        = 4,
  parameter int ACTIVE_LOW = 0
) (
  input logic               clk,
  input logic               rst_n,
  onehot_scan_deco_if.slave bus
);

  localparam int             IW      = $clog2(N);
  localparam int             PW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]  PLAST   = PW'(DIV - 1);
  localparam logic           INACT   = inactive_level(ACTIVE_LOW != 0);
  localparam logic [N-1:0]   ALL_OFF = {N{INACT}};

`ifdef DECO_BLANK_EN
  localparam bit BLANK = 1'b1;
  if (DIV < 2) begin : g_div_check
    $error("onehot_scan_deco: DIV must be at least 2 with DECO_BLANK_EN");
  end
`else
  localparam bit BLANK = 1'b0;
`endif

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0]  out_q, out_d;
  logic          tick_q, tick_d;
  logic          wrap_q, wrap_d;

  logic          find_incl;
  logic [IW-1:0] nxt;
  logic          found;
  logic          wrapped;

  function automatic logic [N-1:0] chan_out(input logic [IW-1:0] i);
    return ({{(N-1){1'b0}}, 1'b1} << i) ^ ALL_OFF;
  endfunction

  // Entry into SCAN may land on the current channel; an advance may not.
  assign find_incl = (state_q != SCAN);

  next_chan_find #(.N(N)) u_find (
    .mask      (bus.mask),
    .cur       (idx_q),
    .inclusive (find_incl),
    .nxt       (nxt),
    .found     (found),
    .wrapped   (wrapped)
  );

  // Next state, prescaler and registered output values for the coming edge.
  always_comb begin
    state_d = state_q;
    presc_d = '0;
    idx_d   = idx_q;
    out_d   = ALL_OFF;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (!bus.en) begin
      state_d = IDLE;
    end else if (bus.mode == MODE_DIRECT) begin
      state_d = DIRECT;
      if (int'(bus.sel) < N) begin
        idx_d = bus.sel;
        out_d = chan_out(bus.sel);
      end
    end else begin
      state_d = SCAN;
      if (state_q != SCAN) begin
        if (found) begin
          idx_d = nxt;
          out_d = chan_out(nxt);
        end
      end else if (presc_q == PLAST) begin
        if (found) begin
          idx_d  = nxt;
          out_d  = chan_out(nxt);
          tick_d = 1'b1;
          wrap_d = wrapped;
        end
      end else begin
        presc_d = presc_q + PW'(1);
        if ((bus.mask != '0) && !(BLANK && (presc_d == PLAST))) begin
          out_d = out_q;
        end
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      idx_q   <= '0;
      out_q   <= ALL_OFF;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.idx  = idx_q;
  assign bus.tick = tick_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_onehot_scan_deco.sv
// Directed self-checking bench for onehot_scan_deco: an N=8 unit, an N=10
// unit for out-of-range selects, and an ACTIVE_LOW unit share clock/reset.
module tb_onehot_scan_deco;
  import deco_pkg::*;

`ifdef DECO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  onehot_scan_deco_if #(.N(8))  b8 ();
  onehot_scan_deco_if #(.N(10)) b10 ();
  onehot_scan_deco_if #(.N(8))  bal ();

  onehot_scan_deco #(.N(8), .DIV(4), .ACTIVE_LOW(0)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(b8));
  onehot_scan_deco #(.N(10), .DIV(4), .ACTIVE_LOW(0)) dut10 (
    .clk(clk), .rst_n(rst_n), .bus(b10));
  onehot_scan_deco #(.N(8), .DIV(4), .ACTIVE_LOW(1)) dutal (
    .clk(clk), .rst_n(rst_n), .bus(bal));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    n_cmp++; if (b8.out !== 8'h00) begin n_err++; $display("[TB] FAIL reset_out: got %h expected %h", b8.out, 8'h00); end
    n_cmp++; if (b8.idx !== 3'd0) begin n_err++; $display("[TB] FAIL reset_idx: got %0d expected 0", b8.idx); end
    n_cmp++; if (b8.tick !== 1'b0) begin n_err++; $display("[TB] FAIL reset_tick: got %b expected 0", b8.tick); end
    n_cmp++; if (bal.out !== 8'hFF) begin n_err++; $display("[TB] FAIL reset_out_al: got %h expected ff", bal.out); end
    rst_n   = 1'b1;
    b8.en   = 1'b1;
    b8.mode = MODE_DIRECT;
    b8.sel  = 3'd5;
    step();
    n_cmp++; if (b8.out !== 8'h20) begin n_err++; $display("[TB] FAIL direct_sel5_out: got %h expected 20", b8.out); end
    n_cmp++; if (b8.idx !== 3'd5) begin n_err++; $display("[TB] FAIL direct_sel5_idx: got %0d expected 5", b8.idx); end
  endtask

  task automatic test_direct_range();
    b10.en = 1'b1; b10.mode = MODE_DIRECT; b10.sel = 4'd3;
    step();
    n_cmp++; if (b10.out !== 10'h008) begin n_err++; $display("[TB] FAIL n10_sel3_out: got %h expected 008", b10.out); end
    b10.sel = 4'd9;
    step();
    n_cmp++; if (b10.out !== 10'h200) begin n_err++; $display("[TB] FAIL n10_sel9_out: got %h expected 200", b10.out); end
    n_cmp++; if (b10.idx !== 4'd9) begin n_err++; $display("[TB] FAIL n10_sel9_idx: got %0d expected 9", b10.idx); end
    b10.sel = 4'd12;
    step();
    n_cmp++; if (b10.out !== 10'h000) begin n_err++; $display("[TB] FAIL n10_sel12_out: got %h expected 000", b10.out); end
    n_cmp++; if (b10.idx !== 4'd9) begin n_err++; $display("[TB] FAIL n10_sel12_idx_hold: got %0d expected 9", b10.idx); end
    b10.en = 1'b0;
    step();
    n_cmp++; if (b10.out !== 10'h000) begin n_err++; $display("[TB] FAIL n10_idle_out: got %h expected 000", b10.out); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    for (int s = 0; s < 8; s++) begin
      b8.sel = 3'(s);
      step();
      e = 8'h01 << s;
      n_cmp++; if (b8.out !== e) begin n_err++; $display("[TB] FAIL b2b_out sel=%0d: got %h expected %h", s, b8.out, e); end
      n_cmp++; if (b8.idx !== 3'(s)) begin n_err++; $display("[TB] FAIL b2b_idx: got %0d expected %0d", b8.idx, s); end
    end
  endtask

  task automatic test_active_low();
    bal.en = 1'b1; bal.mode = MODE_DIRECT; bal.sel = 3'd2;
    step();
    n_cmp++; if (bal.out !== 8'hFB) begin n_err++; $display("[TB] FAIL al_sel2_out: got %h expected fb", bal.out); end
    bal.en = 1'b0;
    step();
    n_cmp++; if (bal.out !== 8'hFF) begin n_err++; $display("[TB] FAIL al_idle_out: got %h expected ff", bal.out); end
  endtask

  task automatic test_scan_full();
    int         ch;
    int         ticks;
    int         wraps;
    logic       et;
    logic       ew;
    logic [7:0] eo;
    ticks = 0;
    wraps = 0;
    b8.mode = MODE_DIRECT; b8.sel = 3'd0;
    step();
    b8.mode = MODE_SCAN; b8.mask = 8'hFF;
    step();
    for (int c = 0; c < 36; c++) begin
      ch = (c / 4) % 8;
      eo = (BLANK && (c % 4 == 3)) ? 8'h00 : (8'h01 << ch);
      et = (c > 0) && (c % 4 == 0);
      ew = et && (ch == 0);
      n_cmp++; if (b8.out !== eo) begin n_err++; $display("[TB] FAIL scan_out c=%0d: got %h expected %h", c, b8.out, eo); end
      n_cmp++; if (b8.tick !== et) begin n_err++; $display("[TB] FAIL scan_tick c=%0d: got %b expected %b", c, b8.tick, et); end
      n_cmp++; if (b8.wrap !== ew) begin n_err++; $display("[TB] FAIL scan_wrap c=%0d: got %b expected %b", c, b8.wrap, ew); end
      if (c >= 1 && c <= 32) begin
        if (b8.tick === 1'b1) ticks++;
        if (b8.wrap === 1'b1) wraps++;
      end
      step();
    end
    n_cmp++; if (ticks !== 8) begin n_err++; $display("[TB] FAIL scan_tick_count: got %0d expected 8", ticks); end
    n_cmp++; if (wraps !== 1) begin n_err++; $display("[TB] FAIL scan_wrap_count: got %0d expected 1", wraps); end
  endtask

  task automatic test_sparse_empty();
    int         seq [4] = '{1, 4, 7, 1};
    logic       et;
    logic [7:0] eo;
    rst_n = 1'b0;
    b8.en = 1'b1; b8.mode = MODE_SCAN; b8.mask = 8'b1001_0010;
    step();
    rst_n = 1'b1;
    step();
    for (int c = 0; c <= 12; c++) begin
      eo = (BLANK && (c % 4 == 3)) ? 8'h00 : (8'h01 << seq[c / 4]);
      et = (c > 0) && (c % 4 == 0);
      n_cmp++; if (b8.idx !== 3'(seq[c / 4])) begin n_err++; $display("[TB] FAIL sparse_idx c=%0d: got %0d expected %0d", c, b8.idx, seq[c / 4]); end
      n_cmp++; if (b8.out !== eo) begin n_err++; $display("[TB] FAIL sparse_out c=%0d: got %h expected %h", c, b8.out, eo); end
      n_cmp++; if (b8.tick !== et) begin n_err++; $display("[TB] FAIL sparse_tick c=%0d: got %b expected %b", c, b8.tick, et); end
      n_cmp++; if (b8.wrap !== (c == 12)) begin n_err++; $display("[TB] FAIL sparse_wrap c=%0d: got %b expected %b", c, b8.wrap, (c == 12)); end
      if (c < 12) step();
    end
    b8.mask = 8'h00;
    for (int c = 0; c < 20; c++) begin
      step();
      n_cmp++; if (b8.out !== 8'h00) begin n_err++; $display("[TB] FAIL empty_out c=%0d: got %h expected 00", c, b8.out); end
      n_cmp++; if (b8.tick !== 1'b0) begin n_err++; $display("[TB] FAIL empty_tick c=%0d: got %b expected 0", c, b8.tick); end
    end
    n_cmp++; if (b8.idx !== 3'd1) begin n_err++; $display("[TB] FAIL empty_idx_hold: got %0d expected 1", b8.idx); end
  endtask

  task automatic test_en_drop();
    rst_n = 1'b0;
    b8.en = 1'b1; b8.mode = MODE_SCAN; b8.mask = 8'hFF;
    step();
    rst_n = 1'b1;
    step();
    repeat (3) step();
    b8.en = 1'b0;
    step();
    n_cmp++; if (b8.out !== 8'h00) begin n_err++; $display("[TB] FAIL endrop_out: got %h expected 00", b8.out); end
    n_cmp++; if (b8.tick !== 1'b0) begin n_err++; $display("[TB] FAIL endrop_tick: got %b expected 0", b8.tick); end
    n_cmp++; if (b8.idx !== 3'd0) begin n_err++; $display("[TB] FAIL endrop_idx: got %0d expected 0", b8.idx); end
  endtask

  task automatic test_reset_mid_scan();
    b8.en = 1'b1; b8.mode = MODE_SCAN; b8.mask = 8'hFF;
    step();
    repeat (24) step();
    n_cmp++; if (b8.idx !== 3'd6) begin n_err++; $display("[TB] FAIL midrst_pre_idx: got %0d expected 6", b8.idx); end
    rst_n = 1'b0;
    step();
    n_cmp++; if (b8.idx !== 3'd0) begin n_err++; $display("[TB] FAIL midrst_idx: got %0d expected 0", b8.idx); end
    n_cmp++; if (b8.out !== 8'h00) begin n_err++; $display("[TB] FAIL midrst_out: got %h expected 00", b8.out); end
    n_cmp++; if (b8.tick !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_tick: got %b expected 0", b8.tick); end
    rst_n = 1'b1;
    step();
    n_cmp++; if (b8.out !== 8'h01) begin n_err++; $display("[TB] FAIL midrst_reentry_out: got %h expected 01", b8.out); end
  endtask

  task automatic test_mode_switch();
    step();
    b8.mode = MODE_DIRECT; b8.sel = 3'd3;
    step();
    n_cmp++; if (b8.out !== 8'h08) begin n_err++; $display("[TB] FAIL modesw_direct_out: got %h expected 08", b8.out); end
    b8.mode = MODE_SCAN;
    step();
    n_cmp++; if (b8.out !== 8'h08) begin n_err++; $display("[TB] FAIL modesw_entry_out: got %h expected 08", b8.out); end
    n_cmp++; if (b8.tick !== 1'b0) begin n_err++; $display("[TB] FAIL modesw_entry_tick: got %b expected 0", b8.tick); end
    repeat (4) step();
    n_cmp++; if (b8.out !== 8'h10) begin n_err++; $display("[TB] FAIL modesw_adv_out: got %h expected 10", b8.out); end
    n_cmp++; if (b8.tick !== 1'b1) begin n_err++; $display("[TB] FAIL modesw_adv_tick: got %b expected 1", b8.tick); end
  endtask

  initial begin
    rst_n = 1'b0;
    b8.en = 1'b0;  b8.mode = MODE_DIRECT;  b8.sel = '0;  b8.mask = '0;
    b10.en = 1'b0; b10.mode = MODE_DIRECT; b10.sel = '0; b10.mask = '0;
    bal.en = 1'b0; bal.mode = MODE_DIRECT; bal.sel = '0; bal.mask = '0;
    test_reset();
    test_direct_range();
    test_back_to_back();
    test_active_low();
    test_scan_full();
    test_sparse_empty();
    test_en_drop();
    test_reset_mid_scan();
    test_mode_switch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
